// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: default data width and counter-width helper.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Counter must hold 0..width-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

  // Even parity of a word, for consumers that append a parity check.
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/deserializer_checker.sv
// Protocol assertions for the deserializer outputs; instantiated alongside the design.
module deserializer_checker
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  deser_en,
  input logic [DATA_WIDTH-1:0] p_data,
  input logic                  deser_done
);

  // A word needs at least DATA_WIDTH strobes, so done can never last two cycles.
  a_done_single : assert property (@(posedge clk) deser_done |=> !deser_done);

  a_reset_clears : assert property (@(posedge clk) rst |=> (!deser_done && (p_data == '0)));

  a_hold_stable : assert property (@(posedge clk) (!rst && !deser_en) |=> $stable(p_data));

endmodule

// File: rtl/deserializer.sv
// UART RX serial-to-parallel converter; one shift per deser_en strobe, done pulse per word.
// Optional build macro: DESER_MSB_FIRST_EN reverses the shift direction (first bit lands in the MSB).
module deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sampled_bit,
  input  logic                  deser_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  deser_done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  done_s;

  // Next-state: shift and count on each strobe, flag the completing shift.
  always_comb begin
    data_s = p_data;
    cnt_s  = cnt_r;
    done_s = 1'b0;
    if (deser_en) begin
`ifdef DESER_MSB_FIRST_EN
      data_s = {p_data[DATA_WIDTH-2:0], sampled_bit};
`else
      data_s = {sampled_bit, p_data[DATA_WIDTH-1:1]};
`endif
      if (cnt_r == LAST_CNT) begin
        cnt_s  = {CNT_W{1'b0}};
        done_s = 1'b1;
      end else begin
        cnt_s  = cnt_r + CNT_ONE;
        done_s = 1'b0;
      end
    end else begin
      data_s = p_data;
      cnt_s  = cnt_r;
      done_s = 1'b0;
    end
  end

  // State register; reset wins over a simultaneous strobe and drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data     <= {DATA_WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      deser_done <= 1'b0;
    end else begin
      p_data     <= data_s;
      cnt_r      <= cnt_s;
      deser_done <= done_s;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: vector table, directed corner sequences, random vs. model.
module tb_deserializer;
  import uart_pkg::*;

  localparam int W = UART_DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         sampled_bit;
  logic         deser_en;
  logic [W-1:0] p_data;
  logic         deser_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         hist[$];
  int         nshift;
  bit         exp_done_m;
  int         done_seen;
  int         done_cyc[$];
  logic [7:0] done_data[$];

  typedef struct {
    bit         r;
    bit         e;
    bit         b;
    logic [7:0] d;
    bit         dn;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  deserializer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sampled_bit(sampled_bit),
    .deser_en   (deser_en),
    .p_data     (p_data),
    .deser_done (deser_done)
  );

  deserializer_checker #(.DATA_WIDTH(W)) chk (
    .clk       (clk),
    .rst       (rst),
    .deser_en  (deser_en),
    .p_data    (p_data),
    .deser_done(deser_done)
  );

  // Word = the last W received bits; newest bit at the MSB (LSB-first) or LSB (MSB-first).
  function automatic logic [W-1:0] model_data();
    logic [W-1:0] v = '0;
    int n = hist.size();
    for (int k = 0; k < n; k++) begin
`ifdef DESER_MSB_FIRST_EN
      v[k] = hist[n-1-k];
`else
      v[W-1-k] = hist[n-1-k];
`endif
    end
    return v;
  endfunction

  // Expected register contents after sending w with bit 0 first.
  function automatic logic [7:0] ord(input logic [7:0] w);
    logic [7:0] r;
`ifdef DESER_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit b);
    rst = r;
    deser_en = e;
    sampled_bit = b;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      hist.delete();
      nshift = 0;
      exp_done_m = 1'b0;
    end else if (e) begin
      hist.push_back(b);
      if (hist.size() > W) void'(hist.pop_front());
      nshift++;
      exp_done_m = ((nshift % W) == 0);
    end else begin
      exp_done_m = 1'b0;
    end
    check("model_data", 32'(p_data), 32'(model_data()));
    check("model_done", 32'(deser_done), 32'(exp_done_m));
    if (deser_done === 1'b1) begin
      done_seen++;
      done_cyc.push_back(cyc);
      done_data.push_back(p_data);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, w[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    logic [7:0] f0_bits;
    logic [7:0] f0_exp[8];
`ifdef DESER_MSB_FIRST_EN
    f0_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0};
`else
    f0_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F};
`endif
    f0_bits = 8'hF0;

    // Reset with strobe active, then 0xF0 sent bit7 first, then one idle cycle.
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 1'b0});
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 1'b1, f0_bits[7-i], f0_exp[i], (i == 7)});
    tbl.push_back('{1'b0, 1'b0, 1'b1, f0_exp[7], 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].b);
      check("tbl_data", 32'(p_data), 32'(tbl[i].d));
      check("tbl_done", 32'(deser_done), 32'(tbl[i].dn));
    end

    // Gapped enable.
    done_seen = 0;
    send_word(8'hA5, 3);
    step(1'b0, 1'b0, 1'b0);
    check("gap_done_count", 32'(done_seen), 32'd1);
    check("gap_data", 32'(p_data), 32'(ord(8'hA5)));

    // Back-to-back words.
    done_cyc.delete();
    done_data.delete();
    send_word(8'h3C, 0);
    send_word(8'hC3, 0);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_pulses", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() == 2) begin
      check("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd8);
      check("b2b_word0", 32'(done_data[0]), 32'(ord(8'h3C)));
      check("b2b_word1", 32'(done_data[1]), 32'(ord(8'hC3)));
    end

    // Mid-word reset (asserted together with a strobe).
    done_seen = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("midrst_data", 32'(p_data), 32'd0);
    send_word(8'h55, 0);
    step(1'b0, 1'b0, 1'b0);
    check("midrst_done_count", 32'(done_seen), 32'd1);
    check("midrst_data_final", 32'(p_data), 32'(ord(8'h55)));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(49) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
